// File: rtl/stream_demux2_if.sv
// stream_demux2_if: input stream, two output streams and per-output beat counters
interface stream_demux2_if #(parameter int WIDTH = 32, parameter int CNT_W = 16);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic [WIDTH-1:0] out1_data;
  logic             out0_valid;
  logic             out1_valid;
  logic             out0_ready;
  logic             out1_ready;
  logic [CNT_W-1:0] out0_cnt;
  logic [CNT_W-1:0] out1_cnt;
  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out1_data, out0_valid, out1_valid, out0_cnt, out1_cnt
  );
  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out1_data, out0_valid, out1_valid, out0_cnt, out1_cnt
  );
endinterface

// File: rtl/stream_demux2.sv
// stream_demux2: routes one valid/ready stream to one of two registered outputs per beat.
// Define STREAM_DEMUX2_SKID_EN to add a 1-entry skid register per output (no comb ready path).
module stream_demux2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  stream_demux2_if.slave io_bus
);
  logic             w_rdy   [2];
  logic             w_space [2];
  logic             w_valid [2];
  logic [WIDTH-1:0] w_data  [2];
  logic [CNT_W-1:0] w_cnt   [2];
  logic             w_acc;
  assign w_rdy[0] = io_bus.out0_ready;
  assign w_rdy[1] = io_bus.out1_ready;
  assign io_bus.in_ready   = !reset && w_space[io_bus.in_sel];
  assign w_acc             = io_bus.in_valid && io_bus.in_ready;
  assign io_bus.out0_data  = w_data[0];
  assign io_bus.out1_data  = w_data[1];
  assign io_bus.out0_valid = w_valid[0];
  assign io_bus.out1_valid = w_valid[1];
  assign io_bus.out0_cnt   = w_cnt[0];
  assign io_bus.out1_cnt   = w_cnt[1];
  for (genvar k = 0; k < 2; k++) begin : g_out
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load;
    logic             w_drain;
    assign w_load  = w_acc && (io_bus.in_sel == 1'(k));
    assign w_drain = r_valid && w_rdy[k];
`ifdef STREAM_DEMUX2_SKID_EN
    logic [WIDTH-1:0] r_skid;
    logic             r_skid_valid;
    assign w_space[k] = !r_skid_valid;
    // a load can't coincide with a full skid because in_ready is low then
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_data       <= '0;
        r_valid      <= 1'b0;
        r_skid       <= '0;
        r_skid_valid <= 1'b0;
      end else if (w_drain) begin
        r_data       <= r_skid_valid ? r_skid : (w_load ? io_bus.in_data : r_data);
        r_valid      <= r_skid_valid || w_load;
        r_skid_valid <= 1'b0;
      end else if (w_load && r_valid) begin
        r_skid       <= io_bus.in_data;
        r_skid_valid <= 1'b1;
      end else if (w_load) begin
        r_data  <= io_bus.in_data;
        r_valid <= 1'b1;
      end
    end
`else
    assign w_space[k] = !r_valid || w_rdy[k];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_data  <= io_bus.in_data;
        r_valid <= 1'b1;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
    end
`endif
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_cnt <= '0;
      else if (w_drain) r_cnt <= r_cnt + 1'b1;
    end
    assign w_data[k]  = r_data;
    assign w_valid[k] = r_valid;
    assign w_cnt[k]   = r_cnt;
  end
endmodule

// File: tb/tb_stream_demux2.sv
// tb_stream_demux2: queue-based model of both outputs checked every cycle, plus directed literal checks.
module tb_stream_demux2;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int CMOD  = 1 << CNT_W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0, n_tot = 0, cyc = 0;
  logic [WIDTH-1:0] q0[$], q1[$], d0[$], d1[$];
  int   t0[$];
  int   c0 = 0, c1 = 0;
  stream_demux2_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  stream_demux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(rst), .io_bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic room(input int sz, input logic rdy);
`ifdef STREAM_DEMUX2_SKID_EN
    return sz < 2;
`else
    return sz == 0 || rdy;
`endif
  endfunction

  // model: each output is a FIFO of capacity 1 (2 with skid); front = what outK must show
  initial forever begin
    logic m_rdy, acc;
    @(negedge clk);
    cyc++;
    if (rst) begin
      q0.delete(); q1.delete(); c0 = 0; c1 = 0;
    end
    m_rdy = rst ? 1'b0 : (bus.in_sel ? room(q1.size(), bus.out1_ready) : room(q0.size(), bus.out0_ready));
    chk("in_ready", bus.in_ready, m_rdy);
    chk("out0_valid", bus.out0_valid, q0.size() > 0);
    chk("out1_valid", bus.out1_valid, q1.size() > 0);
    if (q0.size() > 0) chk("out0_data", bus.out0_data, q0[0]);
    if (q1.size() > 0) chk("out1_data", bus.out1_data, q1[0]);
    chk("out0_cnt", bus.out0_cnt, c0);
    chk("out1_cnt", bus.out1_cnt, c1);
    if (!rst) begin
      acc = bus.in_valid && m_rdy;
      if (q0.size() > 0 && bus.out0_ready) begin
        d0.push_back(q0.pop_front()); t0.push_back(cyc); c0 = (c0 + 1) % CMOD;
      end
      if (q1.size() > 0 && bus.out1_ready) begin
        d1.push_back(q1.pop_front()); c1 = (c1 + 1) % CMOD;
      end
      if (acc && bus.in_sel) q1.push_back(bus.in_data);
      else if (acc) q0.push_back(bus.in_data);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic s, input logic [WIDTH-1:0] d);
    logic got = 1'b0;
    bus.in_valid = 1'b1; bus.in_sel = s; bus.in_data = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!got) chk("send_accept", got, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(2); rst = 1'b0;
    d0.delete(); d1.delete(); t0.delete();
  endtask

  initial begin
    bus.in_data = '0; bus.in_sel = 1'b0; bus.in_valid = 1'b0;
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    idle(1);
    do_reset();
    // mid-stream reset with out0 holding a beat and out1_cnt at 5
    bus.out1_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b1, 32'h40 + i);
    bus.out0_ready = 1'b0;
    send(1'b0, 32'h55);
    idle(1);
    chk("pre_rst_out0_valid", bus.out0_valid, 1'b1);
    chk("pre_rst_out1_cnt", bus.out1_cnt, 5);
    rst = 1'b1; #1;
    chk("async_out0_valid", bus.out0_valid, 1'b0);
    chk("async_out1_valid", bus.out1_valid, 1'b0);
    chk("async_out0_cnt", bus.out0_cnt, 0);
    chk("async_out1_cnt", bus.out1_cnt, 0);
    chk("async_in_ready", bus.in_ready, 1'b0);
    idle(2);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    idle(1);
    chk("post_rst_no_redeliver", bus.out0_valid, 1'b0);
    // streaming to out0
    do_reset();
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(1'b0, 32'h10 + i);
    idle(3);
    chk("stream_count", d0.size(), 8);
    for (int i = 0; i < 8 && i < d0.size(); i++) chk("stream_data", d0[i], 32'h10 + i);
    if (t0.size() == 8) chk("stream_gap", t0[7] - t0[0], 7);
    chk("stream_out1_none", d1.size(), 0);
    chk("stream_cnt0", bus.out0_cnt, 8);
    // alternating select
    do_reset();
    for (int i = 0; i < 4; i++) send(1'(i), 32'hA0 + i);
    idle(3);
    chk("alt_n0", d0.size(), 2);
    chk("alt_n1", d1.size(), 2);
    if (d0.size() == 2) begin chk("alt_d0a", d0[0], 32'hA0); chk("alt_d0b", d0[1], 32'hA2); end
    if (d1.size() == 2) begin chk("alt_d1a", d1[0], 32'hA1); chk("alt_d1b", d1[1], 32'hA3); end
    chk("alt_cnt0", bus.out0_cnt, 2);
    chk("alt_cnt1", bus.out1_cnt, 2);
    // backpressure isolation
    do_reset();
    bus.out1_ready = 1'b0;
    send(1'b1, 32'hB0); send(1'b0, 32'hC0); send(1'b0, 32'hC1);
    idle(3);
    chk("bp_out1_hold", bus.out1_data, 32'hB0);
    chk("bp_out1_valid", bus.out1_valid, 1'b1);
    chk("bp_n0", d0.size(), 2);
    if (d0.size() == 2) begin chk("bp_c0", d0[0], 32'hC0); chk("bp_c1", d0[1], 32'hC1); end
    bus.out1_ready = 1'b1;
    idle(3);
    chk("bp_b0_once", d1.size(), 1);
    if (d1.size() == 1) chk("bp_b0", d1[0], 32'hB0);
    // full output
    do_reset();
    bus.out0_ready = 1'b0;
    send(1'b0, 32'hD0);
`ifdef STREAM_DEMUX2_SKID_EN
    send(1'b0, 32'hD1);
`endif
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'hD2;
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 1'b0);
    idle(2);
    chk("full_hold", bus.out0_data, 32'hD0);
    bus.in_valid = 1'b0;
    bus.out0_ready = 1'b1;
`ifndef STREAM_DEMUX2_SKID_EN
    send(1'b0, 32'hD1);
`endif
    idle(3);
    chk("full_n", d0.size(), 2);
    if (d0.size() == 2) begin chk("full_d0", d0[0], 32'hD0); chk("full_d1", d0[1], 32'hD1); end
    // counter wrap at CNT_W = 4
    do_reset();
    for (int i = 0; i < 15; i++) send(1'b1, i);
    idle(2);
    chk("wrap_15", bus.out1_cnt, 15);
    send(1'b1, 32'h0F); idle(2);
    chk("wrap_16", bus.out1_cnt, 0);
    send(1'b1, 32'h10); idle(2);
    chk("wrap_17", bus.out1_cnt, 1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
